// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV32I controller.
//   state_t   - 15-state main FSM, 4-bit encoding
//   OP_*      - RV32I major opcodes recognised by the controller
//   RES_/SRCA_/SRCB_/ALUOP_/IMM_ - mux select and ALUOp encodings
//   branch_taken() - beq/bne resolution from Zero and funct3
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
    S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Only beq (000) and bne (001) are resolved; the ALU subtracts, so
  // Zero means equal and funct3[0] inverts the sense. Other funct3 never take.
  function automatic logic branch_taken(input logic zero, input logic [2:0] funct3);
    return (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: selects the immediate format for the extender from the opcode.
//   op      in  7  IR[6:0]
//   imm_src out 3  I/S/B/J/U format select, I for anything unrecognised
module imm_src_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port with a mem_req/mem_ready handshake.
//   clk, reset_n         clock, async active-low reset
//   op, funct3, zero     IR fields and ALU Zero flag
//   mem_ready            memory finishes the current access this cycle
//   mem_req, MemWrite, AdrSrc                memory port control
//   IRWrite, PCWrite, RegWrite               architectural write strobes
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp       datapath selects
//   ImmSrc                                   immediate format (from op)
//   illegal_instr                            high while trapped
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal_instr
);

  state_t state, state_nxt;

  logic req_raw, memwr_raw, irwr_raw, pcwr_raw, regwr_raw, ill_raw;

  imm_src_decoder u_imm (.op(op), .imm_src(ImmSrc));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_ITYPE:          state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      end
      // op[5] separates store (0100011) from load (0000011)
      S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_MEMWB:    state_nxt = S_FETCH;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JALR2;
      S_JALR2:    state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_ALUWB;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    req_raw   = 1'b0;
    memwr_raw = 1'b0;
    irwr_raw  = 1'b0;
    pcwr_raw  = 1'b0;
    regwr_raw = 1'b0;
    ill_raw   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        req_raw   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irwr_raw  = mem_ready;
        pcwr_raw  = mem_ready;
      end
      // Branch/JAL target (OldPC + imm) lands in ALUOut here
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        req_raw = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        req_raw   = 1'b1;
        AdrSrc    = 1'b1;
        memwr_raw = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regwr_raw = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: regwr_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_SUB;
        pcwr_raw = branch_taken(zero, funct3);
      end
      // JAL and JALR2: PC <= ALUOut target while ALU forms OldPC+4 for rd
      S_JAL, S_JALR2: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcwr_raw = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      S_TRAP:  ill_raw = 1'b1;
      default: ill_raw = 1'b1;
    endcase
  end

  // Strobes and the request are held off while reset is asserted; the
  // selects still follow the (reset) state so the datapath sees FETCH muxing.
  assign mem_req       = req_raw   & reset_n;
  assign MemWrite      = memwr_raw & reset_n;
  assign IRWrite       = irwr_raw  & reset_n;
  assign PCWrite       = pcwr_raw  & reset_n;
  assign RegWrite      = regwr_raw & reset_n;
  assign illegal_instr = ill_raw   & reset_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into its list of control steps, and each step's required outputs are built
// from the step name plus the current inputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    ncyc     = 0;
  bit    all_rdy  = 1'b0;
  bit    exp_valid = 1'b0;
  logic [17:0] exp_v;
  string exp_name = "";

  wire [17:0] act_v = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t op=%b f3=%b)", name, act, req, $time, op, funct3);
    end
  endtask

  always @(negedge clk)
    if (exp_valid) chk({"step ", exp_name}, 32'(act_v), 32'(exp_v));

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Required outputs of one control step, straight from the step descriptions.
  function automatic logic [17:0] model(input string st, input bit rdy);
    logic req = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0, aop = 0;
    case (st)
      "FETCH":    begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      "DECODE":   begin a = 2'b01; b = 2'b01; end
      "MEMADR":   begin a = 2'b10; b = 2'b01; end
      "MEMREAD":  begin req = 1; adr = 1; end
      "MEMWRITE": begin req = 1; adr = 1; mw = 1; end
      "MEMWB":    begin res = 2'b01; rw = 1; end
      "EXEC_R":   begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      "EXEC_I":   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      "ALUWB":    begin rw = 1; end
      "BRANCH":   begin a = 2'b10; aop = 2'b01;
                        pcw = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero); end
      "JAL":      begin a = 2'b01; b = 2'b10; pcw = 1; end
      "JALR":     begin a = 2'b10; b = 2'b01; end
      "JALR2":    begin a = 2'b01; b = 2'b10; pcw = 1; end
      "LUI":      begin a = 2'b11; b = 2'b01; end
      "TRAP":     begin ill = 1; end
      default:    begin ill = 1'bx; end
    endcase
    return {req, mw, adr, irw, pcw, rw, res, a, b, aop, imm_of(op), ill};
  endfunction

  task automatic step(input string st, input bit rdy);
    mem_ready = rdy;
    exp_name  = st;
    exp_v     = model(st, rdy);
    exp_valid = 1'b1;
    ncyc++;
    @(posedge clk); #1;
  endtask

  task automatic mem_step(input string st, input int waits);
    repeat (waits) step(st, 1'b0);
    step(st, 1'b1);
  endtask

  function automatic bit rb();
    return all_rdy ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_req"},   32'(mem_req), 0);
    chk({tag, " strobes"},   32'({MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr}), 0);
    chk({tag, " selects"},   32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}), 32'b0_10_00_10_00);
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks, releases next cycle.
  task automatic reset_pulse(input string tag);
    exp_valid = 1'b0;
    mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs(tag);
    @(posedge clk); #1;
    chk_reset_outputs(tag);
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input int fw, input int mw);
    op = o; funct3 = f3; zero = z; ncyc = 0;
    mem_step("FETCH", fw);
    step("DECODE", rb());
    case (o)
      7'b0000011: begin step("MEMADR", rb()); mem_step("MEMREAD", mw); step("MEMWB", rb()); end
      7'b0100011: begin step("MEMADR", rb()); mem_step("MEMWRITE", mw); end
      7'b0110011: begin step("EXEC_R", rb()); step("ALUWB", rb()); end
      7'b0010011: begin step("EXEC_I", rb()); step("ALUWB", rb()); end
      7'b1100011: step("BRANCH", rb());
      7'b1101111: begin step("JAL", rb()); step("ALUWB", rb()); end
      7'b1100111: begin step("JALR", rb()); step("JALR2", rb()); step("ALUWB", rb()); end
      7'b0110111: begin step("LUI", rb()); step("ALUWB", rb()); end
      default: begin
        repeat (12) step("TRAP", 1'($urandom_range(0, 1)));
        chk("trap illegal_instr", 32'(illegal_instr), 1);
        chk("trap mem_req", 32'(mem_req), 0);
        reset_pulse("trap reset");
      end
    endcase
  endtask

  logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    reset_n = 1'b0; op = 7'b0; funct3 = 3'b0; zero = 1'b0; mem_ready = 1'b1;
    #2 chk_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset abandons a stalled load.
    op = 7'b0000011; funct3 = 3'b010;
    mem_step("FETCH", 0); step("DECODE", 1); step("MEMADR", 1); step("MEMREAD", 0);
    exp_valid = 1'b0; mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid-memread");
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post-reset mem_req", 32'(mem_req), 1);
    chk("post-reset AdrSrc", 32'(AdrSrc), 0);
    chk("post-reset strobes", 32'({RegWrite, MemWrite, IRWrite}), 0);

    // Directed latencies (step counts are hand-derived cycle totals).
    all_rdy = 1'b1;
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0); chk("lat R", 32'(ncyc), 4);
    all_rdy = 1'b0;
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3); chk("lat lw wait3", 32'(ncyc), 8);
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0); chk("lat lw", 32'(ncyc), 5);
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 0); chk("lat sw", 32'(ncyc), 4);
    run_instr(7'b1100011, 3'b000, 1'b1, 0, 0); chk("lat beq", 32'(ncyc), 3);
    run_instr(7'b1100011, 3'b001, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0);
    run_instr(7'b1100011, 3'b100, 1'b1, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0); chk("lat jal", 32'(ncyc), 4);
    run_instr(7'b1100111, 3'b000, 1'b0, 0, 0); chk("lat jalr", 32'(ncyc), 5);
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0); chk("lat lui", 32'(ncyc), 4);
    run_instr(7'b0010011, 3'b000, 1'b0, 1, 0); chk("lat I fetch wait", 32'(ncyc), 5);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);

    // Randomized mix, with an occasional undefined opcode.
    for (int i = 0; i < 200; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    exp_valid = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
